// File: rtl/debug_unit_pkg.sv
// Shared constants and state encoding for the UART debug dump controller.
// Command bytes are ASCII; the FSM state is one-hot.
package debug_unit_pkg;

    localparam logic [7:0] CMD_PING   = 8'h61; // 'a'
    localparam logic [7:0] CMD_SNAP   = 8'h73; // 's'
    localparam logic [7:0] CMD_RESEND = 8'h72; // 'r'
    localparam logic [7:0] CMD_HALT   = 8'h68; // 'h'
    localparam logic [7:0] CMD_CONT   = 8'h63; // 'c'
    localparam logic [7:0] CMD_STEP   = 8'h6E; // 'n'
    localparam logic [7:0] BYTE_ACK   = 8'h70; // 'p'
    localparam logic [7:0] BYTE_NAK   = 8'h3F; // '?'

    typedef enum logic [3:0] {
        ST_IDLE      = 4'b0001,
        ST_DECODE    = 4'b0010,
        ST_SEND      = 4'b0100,
        ST_WAIT_DONE = 4'b1000
    } state_t;

    function automatic int num_bytes(input int dbg_w, input int data_w);
        return (dbg_w + data_w - 1) / data_w;
    endfunction

endpackage

// File: rtl/debug_byte_serializer.sv
// Snapshot register plus byte counter: presents the frozen debug bus one byte at a
// time, LSB byte first, with the top byte zero-padded above DBG_W-1.
module debug_byte_serializer
    import debug_unit_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DBG_W  = 322
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DBG_W-1:0]  debug_signal,
    input  logic              load,
    input  logic              rewind,
    input  logic              next,
    output logic [DATA_W-1:0] byte_out,
    output logic              last
);

    localparam int NBYTES = num_bytes(DBG_W, DATA_W);
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [DBG_W-1:0]         snapshot;
    logic [CNT_W-1:0]         cnt;
    logic [NBYTES*DATA_W-1:0] padded;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snapshot <= '0;
            cnt      <= '0;
        end else begin
            if (load) snapshot <= debug_signal;
            if (load || rewind) cnt <= '0;
            else if (next && !last) cnt <= cnt + CNT_W'(1);
        end
    end

    // NOTE: default the whole vector first so the partial overwrite cannot infer a latch.
    always_comb begin
        padded              = '0;
        padded[DBG_W-1:0]   = snapshot;
    end

    assign last     = (cnt == CNT_W'(NBYTES - 1));
    assign byte_out = padded[cnt*DATA_W +: DATA_W];

endmodule

// File: rtl/debug_dump_unit.sv
// UART-side debug controller: decodes single-byte commands, gates the CPU clock
// enable (run/halt/step) and streams a debug-bus snapshot back over UART TX.
module debug_dump_unit
    import debug_unit_pkg::*;
#(
    parameter int   DATA_W       = 8,
    parameter int   DBG_W        = 322,
    parameter logic RUN_AT_RESET = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_done,
    input  logic              tx_done,
    input  logic [DBG_W-1:0]  debug_signal,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    output logic              cpu_run,
    output logic              cpu_step,
    output logic              busy,
    output logic              cmd_dropped
);

    localparam logic [DATA_W-1:0] C_PING   = DATA_W'(CMD_PING);
    localparam logic [DATA_W-1:0] C_SNAP   = DATA_W'(CMD_SNAP);
    localparam logic [DATA_W-1:0] C_RESEND = DATA_W'(CMD_RESEND);
    localparam logic [DATA_W-1:0] C_HALT   = DATA_W'(CMD_HALT);
    localparam logic [DATA_W-1:0] C_CONT   = DATA_W'(CMD_CONT);
    localparam logic [DATA_W-1:0] C_STEP   = DATA_W'(CMD_STEP);
    localparam logic [DATA_W-1:0] C_ACK    = DATA_W'(BYTE_ACK);
    localparam logic [DATA_W-1:0] C_NAK    = DATA_W'(BYTE_NAK);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] cmd, resp_byte, ser_byte;
    logic              dumping;
    logic              ser_load, ser_rewind, ser_next, ser_last;

    debug_byte_serializer #(.DATA_W(DATA_W), .DBG_W(DBG_W)) u_ser (
        .clk          (clk),
        .rst_n        (rst_n),
        .debug_signal (debug_signal),
        .load         (ser_load),
        .rewind       (ser_rewind),
        .next         (ser_next),
        .byte_out     (ser_byte),
        .last         (ser_last)
    );

    always_comb begin
        state_nxt  = state;
        ser_load   = 1'b0;
        ser_rewind = 1'b0;
        ser_next   = 1'b0;
        case (state)
            ST_IDLE:   if (rx_done) state_nxt = ST_DECODE;
            ST_DECODE: begin
                state_nxt  = ST_SEND;
                ser_load   = (cmd == C_SNAP);
                ser_rewind = (cmd == C_RESEND);
            end
            ST_SEND:   state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    if (dumping && !ser_last) begin
                        ser_next  = 1'b1;
                        state_nxt = ST_SEND;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cmd         <= '0;
            resp_byte   <= '0;
            dumping     <= 1'b0;
            cpu_run     <= RUN_AT_RESET;
            cpu_step    <= 1'b0;
            cmd_dropped <= 1'b0;
        end else begin
            state    <= state_nxt;
            cpu_step <= 1'b0;
            if (rx_done) begin
                if (state == ST_IDLE) cmd <= rx_data;
                else                  cmd_dropped <= 1'b1;
            end
            if (state == ST_DECODE) begin
                resp_byte <= C_ACK;
                dumping   <= 1'b0;
                case (cmd)
                    C_PING:           ;
                    C_SNAP, C_RESEND: dumping <= 1'b1;
                    C_HALT:           cpu_run <= 1'b0;
                    C_CONT:           cpu_run <= 1'b1;
                    C_STEP: begin
                        if (!cpu_run) cpu_step  <= 1'b1;
                        else          resp_byte <= C_NAK;
                    end
                    default:          resp_byte <= C_NAK;
                endcase
            end
            if (state == ST_WAIT_DONE && state_nxt == ST_IDLE) dumping <= 1'b0;
        end
    end

    // During a dump the byte comes straight from the frozen snapshot, so it is stable until tx_done.
    assign tx_data  = dumping ? ser_byte : resp_byte;
    assign tx_start = (state == ST_SEND);
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_debug_dump_unit.sv
// Directed bench for debug_dump_unit: ping, dump, frozen snapshot/resend, run control,
// unknown/overlapping commands and reset in the middle of a dump.
module tb_debug_dump_unit;

    localparam int DATA_W = 8;
    localparam int DBG_W  = 322;
    localparam int NBYTES = 41;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] rx_data;
    logic              rx_done;
    logic              tx_done;
    logic [DBG_W-1:0]  debug_signal;
    logic [DATA_W-1:0] tx_data;
    logic              tx_start;
    logic              cpu_run;
    logic              cpu_step;
    logic              busy;
    logic              cmd_dropped;

    int checks   = 0;
    int failures = 0;
    int steps;
    int first_cyc;
    logic [7:0] got[$];

    debug_dump_unit #(.DATA_W(DATA_W), .DBG_W(DBG_W), .RUN_AT_RESET(1'b0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .tx_done      (tx_done),
        .debug_signal (debug_signal),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .cpu_run      (cpu_run),
        .cpu_step     (cpu_step),
        .busy         (busy),
        .cmd_dropped  (cmd_dropped)
    );

    always #5 clk = ~clk;

    // Pattern A: byte i = 7*i+3, top two bits 2'b10. Pattern B: byte i = 11*i+0x55, top bits 2'b01.
    function automatic logic [7:0] exp_byte(input int i, input int sel);
        if (i == NBYTES - 1) return (sel == 0) ? 8'h02 : 8'h01;
        return (sel == 0) ? 8'(i * 7 + 3) : 8'(i * 11 + 8'h55);
    endfunction

    function automatic logic [DBG_W-1:0] make_sig(input int sel);
        logic [DBG_W-1:0] s;
        logic [7:0]       b;
        s = '0;
        for (int i = 0; i < NBYTES - 1; i++) s[i*8 +: 8] = exp_byte(i, sel);
        b = exp_byte(NBYTES - 1, sel);
        s[321:320] = b[1:0];
        return s;
    endfunction

    task automatic send_cmd(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        steps   = 0;
        @(posedge clk); #1;
        rx_done = 1'b0;
        if (cpu_step) steps++;
    endtask

    // Answers each tx_start with tx_done three cycles later until the unit goes idle.
    task automatic serve(input int inject_at, input logic [7:0] inject_byte,
                         input int change_at, input int abort_n);
        int cyc      = 0;
        int wait_cnt = 0;
        got.delete();
        first_cyc = -1;
        do begin
            @(posedge clk); #1;
            cyc++;
            tx_done = 1'b0;
            rx_done = 1'b0;
            if (cyc == inject_at) begin rx_data = inject_byte; rx_done = 1'b1; end
            if (cyc == change_at) debug_signal = make_sig(1);
            if (cpu_step) steps++;
            if (tx_start) begin
                got.push_back(tx_data);
                if (first_cyc < 0) first_cyc = cyc;
                wait_cnt = 3;
                if (abort_n > 0 && got.size() == abort_n) return;
            end else if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) tx_done = 1'b1;
            end
        end while (busy && cyc < 1000);
        rx_done = 1'b0;
        checks++;
        if (cyc >= 1000) begin
            failures++;
            $display("FAIL serve_timeout: busy=%0b after %0d cycles, required idle", busy, cyc);
        end
    endtask

    task automatic check_stream(input string name, input int sel);
        checks++;
        if (got.size() != NBYTES) begin
            failures++;
            $display("FAIL %s_len: got %0d bytes, required %0d", name, got.size(), NBYTES);
        end else begin
            for (int i = 0; i < NBYTES; i++) begin
                checks++;
                if (got[i] !== exp_byte(i, sel)) begin
                    failures++;
                    $display("FAIL %s_byte%0d: got %02h, required %02h", name, i, got[i], exp_byte(i, sel));
                end
            end
        end
    endtask

    task automatic check_single(input string name, input logic [7:0] exp, input int exp_steps);
        checks++;
        if (got.size() != 1 || got[0] !== exp) begin
            failures++;
            $display("FAIL %s_resp: got %0d bytes first=%02h, required 1 byte %02h",
                     name, got.size(), (got.size() > 0) ? got[0] : 8'hxx, exp);
        end
        checks++;
        if (steps != exp_steps) begin
            failures++;
            $display("FAIL %s_steps: got %0d cpu_step pulses, required %0d", name, steps, exp_steps);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({tx_start, tx_data, cpu_run, cpu_step, busy, cmd_dropped} !== 13'h0) begin
            failures++;
            $display("FAIL %s: tx_start=%0b tx_data=%02h run=%0b step=%0b busy=%0b dropped=%0b, required all 0",
                     name, tx_start, tx_data, cpu_run, cpu_step, busy, cmd_dropped);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_values");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("after_release");
    endtask

    task automatic test_ping();
        send_cmd(8'h61);
        checks++;
        if (busy !== 1'b1 || tx_start !== 1'b0) begin
            failures++;
            $display("FAIL ping_decode: busy=%0b tx_start=%0b, required busy=1 tx_start=0", busy, tx_start);
        end
        serve(0, 8'h00, 0, 0);
        check_single("ping", 8'h70, 0);
        checks++;
        if (first_cyc != 1) begin
            failures++;
            $display("FAIL ping_latency: first tx_start %0d cycles after decode, required 1", first_cyc);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ping_busy_drop: busy=%0b, required 0", busy);
        end
    endtask

    task automatic test_dump();
        debug_signal = make_sig(0);
        send_cmd(8'h73);
        serve(0, 8'h00, 0, 0);
        check_stream("dump", 0);
    endtask

    task automatic test_frozen_resend();
        debug_signal = make_sig(0);
        send_cmd(8'h73);
        serve(0, 8'h00, 30, 0);
        check_stream("frozen", 0);
        send_cmd(8'h72);
        serve(0, 8'h00, 0, 0);
        check_stream("resend", 0);
    endtask

    task automatic test_run_control();
        checks++;
        if (cpu_run !== 1'b0) begin
            failures++;
            $display("FAIL run_reset: cpu_run=%0b, required 0", cpu_run);
        end
        send_cmd(8'h6E);
        serve(0, 8'h00, 0, 0);
        check_single("step_halted", 8'h70, 1);
        send_cmd(8'h63);
        serve(0, 8'h00, 0, 0);
        check_single("continue", 8'h70, 0);
        checks++;
        if (cpu_run !== 1'b1) begin
            failures++;
            $display("FAIL continue_run: cpu_run=%0b, required 1", cpu_run);
        end
        send_cmd(8'h6E);
        serve(0, 8'h00, 0, 0);
        check_single("step_running", 8'h3F, 0);
        send_cmd(8'h68);
        serve(0, 8'h00, 0, 0);
        check_single("halt", 8'h70, 0);
        checks++;
        if (cpu_run !== 1'b0) begin
            failures++;
            $display("FAIL halt_run: cpu_run=%0b, required 0", cpu_run);
        end
    endtask

    task automatic test_unknown_overlap();
        int extra = 0;
        send_cmd(8'h78);
        serve(0, 8'h00, 0, 0);
        check_single("unknown", 8'h3F, 0);
        checks++;
        if (cmd_dropped !== 1'b0) begin
            failures++;
            $display("FAIL dropped_clear: cmd_dropped=%0b, required 0", cmd_dropped);
        end
        debug_signal = make_sig(0);
        send_cmd(8'h73);
        serve(20, 8'h61, 0, 0);
        check_stream("overlap", 0);
        checks++;
        if (cmd_dropped !== 1'b1) begin
            failures++;
            $display("FAIL dropped_set: cmd_dropped=%0b, required 1", cmd_dropped);
        end
        repeat (10) begin
            @(posedge clk); #1;
            if (tx_start) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL dropped_not_run: %0d tx_start after dump, required 0", extra);
        end
    endtask

    task automatic test_reset_mid_dump();
        int extra = 0;
        debug_signal = make_sig(1);
        send_cmd(8'h73);
        serve(0, 8'h00, 0, 10);
        checks++;
        if (got.size() != 10 || got[9] !== exp_byte(9, 1)) begin
            failures++;
            $display("FAIL abort_prefix: got %0d bytes, required 10 ending %02h", got.size(), exp_byte(9, 1));
        end
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tx_done = (i % 4 == 3);
            @(posedge clk); #1;
            if (tx_start) extra++;
        end
        tx_done = 1'b0;
        checks++;
        if (extra != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_quiet: %0d tx_start busy=%0b, required 0 and 0", extra, busy);
        end
        send_cmd(8'h61);
        serve(0, 8'h00, 0, 0);
        check_single("ping_after_abort", 8'h70, 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        rx_data      = '0;
        rx_done      = 1'b0;
        tx_done      = 1'b0;
        debug_signal = '0;
        steps        = 0;
        test_reset();
        test_ping();
        test_dump();
        test_frozen_resend();
        test_run_control();
        test_unknown_overlap();
        test_reset_mid_dump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
